eth_scrambler_pipe: RTL and testbench
=====================================

# eth_scrambler_pipe

Parametrised, self-synchronous 64b/66b scrambler/descrambler (polynomial x^58 + x^39 + 1) with a valid/ready stream interface, one registered pipeline stage, runtime bypass and seed preload. It sits in the Ethernet PCS datapath between the encoder/gearbox and the SerDes in scramble mode, or between the SerDes/block-lock and the decoder in descramble mode. It generalises the earlier fixed scrambler in datapath width and direction, and adds handshaking, which that scrambler lacks.

## Interface

- DATA_WIDTH, 64: payload bits per beat; any value 8..64 is legal.
- DESCRAMBLE, 0: 0 = scrambler (state fed from output bits), 1 = descrambler (state fed from input bits).
- RESET_SEED, 58'h3FF_FFFF_FFFF_FFFF: state value after reset.

- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  DATA_WIDTH  input payload; bit 0 is first on the wire.
- i_hdr  in  2  sync header sideband; never scrambled.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts an input beat.
- o_data  out  DATA_WIDTH  (de)scrambled payload.
- o_hdr  out  2  header, delayed to stay aligned with o_data.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- i_bypass  in  1  pass payload unmodified; sampled per accepted beat.
- i_seed_load  in  1  load state from i_seed.
- i_seed  in  58  preload value.

## Operation

- State s[57:0]: s[0] is the most recent bit, s[57] the oldest.
- Per payload bit i, in order 0..DATA_WIDTH-1: o[i] = d[i] ^ s[38] ^ s[57]. Then shift s left by one and insert the feedback bit at s[0]: o[i] when scrambling, d[i] when descrambling.
- The whole beat is unrolled combinationally, so bit i uses the state already updated by bits 0..i-1. The state register holds the value after the last bit.
- Accept condition: i_valid && o_ready. The state advances only on accepted beats.
- Bypass on an accepted beat: o_data = i_data, and the state is not updated.
- i_seed_load:
  - Without an accept in the same cycle: s <= i_seed.
  - With an accept in the same cycle: the beat is processed starting from i_seed, and s <= the post-beat state.
- The header passes through unchanged, with the same latency as the payload.
- The block has no state machine beyond the output register and the state register. Width rules: state is 58 bits, and nothing is truncated for DATA_WIDTH < 58.

## Timing

- Reset (i_rst high on a rising edge):
  - o_valid = 0, o_data = 0, o_hdr = 0.
  - s = RESET_SEED.
  - o_ready = 1 from the first cycle after reset deasserts.
  - Reset overrides seed load and any accept in the same cycle.
- o_ready = !o_valid || i_ready. This is combinational; the block has no bubble, so throughput is one beat per cycle.
- Latency: a beat accepted at edge N is presented on o_data/o_hdr with o_valid = 1 after edge N.
- Backpressure: while o_valid && !i_ready, o_data/o_hdr/o_valid hold stable, o_ready = 0, and s is frozen.
- Output update: accepted beat -> load; o_valid && i_ready without a new beat -> o_valid <= 0, and o_data holds its last value.
- Reset asserted mid-stream: the in-flight output beat is dropped, and the next accepted beat uses RESET_SEED.
- i_bypass and i_seed_load are meaningful only at accept edges (seed load at any edge). Neither affects a beat already in the output register.

## Test plan

- Reset, DATA_WIDTH=64, DESCRAMBLE=0, i_data=64'h0 accepted, i_ready=1 -> next cycle o_data=64'h03FF_FF80_0000_0000, o_valid=1, o_hdr equals the input header.
- Loopback: scrambler (seed all-ones) drives a descrambler (seed 58'h0) with 1000 random 64-bit beats -> descrambler output equals the source from beat 2 onward; beat 1 bits 0..57 may differ.
- Backpressure: i_ready held low for 5 cycles with i_valid=1 -> o_data constant, o_ready=0, no beat lost or duplicated. Compare against a software model after release.
- Bypass: beat A scrambled, beat B with i_bypass=1, beat C scrambled -> o_data(B)=i_data(B). C matches a model in which B never occurred.
- Seed load with a simultaneous accept, i_seed=58'h0, i_data=0 -> o_data=0, and subsequent zero beats stay 0.
- DATA_WIDTH=32, 200 random beats through scramble -> descramble with matching seeds -> exact match from beat 1. i_rst pulsed mid-stream -> o_valid=0 on the next cycle, and the first post-reset beat matches a model restarted from RESET_SEED.

Source files
------------

// File: rtl/eth_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : eth_scrambler_pipe
// Brief    : Self-synchronous x^58 + x^39 + 1 (de)scrambler for 64b/66b PCS,
//            valid/ready stream with one registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module eth_scrambler_pipe #(
    parameter int          DATA_WIDTH = 64,
    parameter bit          DESCRAMBLE = 1'b0,
    parameter logic [57:0] RESET_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_hdr,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_hdr,
    output logic                  o_valid,
    input  logic                  i_ready,
    input  logic                  i_bypass,
    input  logic                  i_seed_load,
    input  logic [57:0]           i_seed
);

    localparam int c_STATE_W = 58;

    logic [c_STATE_W-1:0]  r_state_q;
    logic [c_STATE_W-1:0]  w_state_d;
    logic [c_STATE_W-1:0]  w_state_start;
    logic [c_STATE_W-1:0]  w_state_post;
    logic [DATA_WIDTH-1:0] w_scr;
    logic [DATA_WIDTH-1:0] w_data_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_hdr_q;
    logic                  r_valid_q;
    logic                  w_accept;

    assign o_ready       = !r_valid_q || i_ready;
    assign w_accept      = i_valid && o_ready;
    assign w_state_start = i_seed_load ? i_seed : r_state_q;

    // Bit-serial recurrence unrolled across the beat; bit 0 sees the oldest state.
    always_comb begin : p_unroll
        logic [c_STATE_W-1:0] w_s;
        logic                 w_bit;
        w_s   = w_state_start;
        w_bit = 1'b0;
        w_scr = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_bit    = i_data[i] ^ w_s[38] ^ w_s[57];
            w_scr[i] = w_bit;
            w_s      = {w_s[c_STATE_W-2:0], (DESCRAMBLE ? i_data[i] : w_bit)};
        end
        w_state_post = w_s;
    end

    // A bypassed beat leaves the state alone, but a coincident seed load still lands.
    always_comb begin
        w_state_d = r_state_q;
        if (w_accept && !i_bypass) begin
            w_state_d = w_state_post;
        end else if (i_seed_load) begin
            w_state_d = i_seed;
        end
    end

    assign w_data_d = i_bypass ? i_data : w_scr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= RESET_SEED;
            r_data_q  <= '0;
            r_hdr_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            if (w_accept) begin
                r_data_q  <= w_data_d;
                r_hdr_q   <= i_hdr;
                r_valid_q <= 1'b1;
            end else if (i_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    assign o_data  = r_data_q;
    assign o_hdr   = r_hdr_q;
    assign o_valid = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_scrambler_pipe
// Brief    : Randomised bench for eth_scrambler_pipe, checked against a
//            stream-equation model (o[n] = d[n] ^ f[n-39] ^ f[n-58]).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_scrambler_pipe;

    localparam logic [57:0] c_SEED_ONES = '1;
    localparam int          c_FB_DEPTH  = 72000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- 64-bit chain: scrambler A -> descrambler B ----------------
    logic        rst_a = 1'b1;
    logic [63:0] data_a = '0;
    logic [1:0]  hdr_a = '0;
    logic        valid_a = 1'b0, bypass_a = 1'b0, seed_load_a = 1'b0;
    logic [57:0] seed_a = '0;
    logic        o_ready_a, o_valid_a;
    logic [63:0] o_data_a;
    logic [1:0]  o_hdr_a;
    logic        o_ready_b, o_valid_b;
    logic [63:0] o_data_b;
    logic [1:0]  o_hdr_b;

    // ---------------- 32-bit chain: scrambler C -> descrambler D ----------------
    logic        rst_c = 1'b1;
    logic [31:0] data_c = '0;
    logic [1:0]  hdr_c = '0;
    logic        valid_c = 1'b0;
    logic        o_ready_c, o_valid_c;
    logic [31:0] o_data_c;
    logic [1:0]  o_hdr_c;
    logic        o_ready_d, o_valid_d;
    logic [31:0] o_data_d;
    logic [1:0]  o_hdr_d;

    logic bp_rand = 1'b0, rnd_ready = 1'b1, ready_force = 1'b1, chk_b = 1'b1;
    logic w_ready_b, w_ready_d;
    assign w_ready_b = bp_rand ? rnd_ready : ready_force;
    assign w_ready_d = bp_rand ? rnd_ready : 1'b1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    eth_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b0), .RESET_SEED(c_SEED_ONES)) u_scr64 (
        .i_clk(clk), .i_rst(rst_a), .i_data(data_a), .i_hdr(hdr_a), .i_valid(valid_a),
        .o_ready(o_ready_a), .o_data(o_data_a), .o_hdr(o_hdr_a), .o_valid(o_valid_a),
        .i_ready(o_ready_b), .i_bypass(bypass_a), .i_seed_load(seed_load_a), .i_seed(seed_a));

    eth_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1), .RESET_SEED(58'h0)) u_des64 (
        .i_clk(clk), .i_rst(rst_a), .i_data(o_data_a), .i_hdr(o_hdr_a), .i_valid(o_valid_a),
        .o_ready(o_ready_b), .o_data(o_data_b), .o_hdr(o_hdr_b), .o_valid(o_valid_b),
        .i_ready(w_ready_b), .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(58'h0));

    eth_scrambler_pipe #(.DATA_WIDTH(32), .DESCRAMBLE(1'b0), .RESET_SEED(c_SEED_ONES)) u_scr32 (
        .i_clk(clk), .i_rst(rst_c), .i_data(data_c), .i_hdr(hdr_c), .i_valid(valid_c),
        .o_ready(o_ready_c), .o_data(o_data_c), .o_hdr(o_hdr_c), .o_valid(o_valid_c),
        .i_ready(o_ready_d), .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(58'h0));

    eth_scrambler_pipe #(.DATA_WIDTH(32), .DESCRAMBLE(1'b1), .RESET_SEED(c_SEED_ONES)) u_des32 (
        .i_clk(clk), .i_rst(rst_c), .i_data(o_data_c), .i_hdr(o_hdr_c), .i_valid(o_valid_c),
        .o_ready(o_ready_d), .o_data(o_data_d), .o_hdr(o_hdr_d), .o_valid(o_valid_d),
        .i_ready(w_ready_d), .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(58'h0));

    task automatic check_eq(input string tag, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model: whole feedback stream, seed first ----------------
    bit fb [0:1][0:c_FB_DEPTH-1];
    int fbn [0:1];

    task automatic model_reset(input int m, input logic [57:0] seed);
        for (int k = 0; k < 58; k++) fb[m][k] = seed[57-k];
        fbn[m] = 58;
    endtask

    task automatic model_beat(input int m, input logic [63:0] d, input int w, output logic [63:0] o);
        o = '0;
        for (int i = 0; i < w; i++) begin
            int n = fbn[m];
            o[i] = d[i] ^ fb[m][n-39] ^ fb[m][n-58];
            if (n < c_FB_DEPTH) fb[m][n] = o[i];
            fbn[m] = n + 1;
        end
    endtask

    logic [65:0] exp_a[$], src_b[$], exp_c[$], src_d[$];
    int b_beats = 0;

    always @(negedge clk) begin : p_mon_64
        logic [63:0] e;
        logic [65:0] x;
        if (rst_a) begin
            exp_a.delete(); src_b.delete();
            model_reset(0, c_SEED_ONES);
            b_beats = 0;
        end else begin
            if (o_valid_a && o_ready_b) begin
                check_eq("a_out_expected", 66'(exp_a.size() != 0), 66'd1);
                if (exp_a.size() != 0) begin
                    x = exp_a.pop_front();
                    check_eq("a_data", 66'(o_data_a), 66'(x[63:0]));
                    check_eq("a_hdr", 66'(o_hdr_a), 66'(x[65:64]));
                end
            end
            if (o_valid_b && w_ready_b && chk_b) begin
                check_eq("b_out_expected", 66'(src_b.size() != 0), 66'd1);
                if (src_b.size() != 0) begin
                    x = src_b.pop_front();
                    if (b_beats == 0) check_eq("b_data_first", 66'(o_data_b[63:58]), 66'(x[63:58]));
                    else check_eq("b_data", 66'(o_data_b), 66'(x[63:0]));
                    check_eq("b_hdr", 66'(o_hdr_b), 66'(x[65:64]));
                end
                b_beats++;
            end
            if (seed_load_a) model_reset(0, seed_a);
            if (valid_a && o_ready_a) begin
                if (bypass_a) e = data_a;
                else model_beat(0, data_a, 64, e);
                exp_a.push_back({hdr_a, e});
                if (chk_b) src_b.push_back({hdr_a, data_a});
            end
        end
    end

    always @(negedge clk) begin : p_mon_32
        logic [63:0] e;
        logic [65:0] x;
        if (rst_c) begin
            exp_c.delete(); src_d.delete();
            model_reset(1, c_SEED_ONES);
        end else begin
            if (o_valid_c && o_ready_d) begin
                check_eq("c_out_expected", 66'(exp_c.size() != 0), 66'd1);
                if (exp_c.size() != 0) begin
                    x = exp_c.pop_front();
                    check_eq("c_data", 66'(o_data_c), 66'(x[31:0]));
                    check_eq("c_hdr", 66'(o_hdr_c), 66'(x[65:64]));
                end
            end
            if (o_valid_d && w_ready_d) begin
                check_eq("d_out_expected", 66'(src_d.size() != 0), 66'd1);
                if (src_d.size() != 0) begin
                    x = src_d.pop_front();
                    check_eq("d_data", 66'(o_data_d), 66'(x[31:0]));
                    check_eq("d_hdr", 66'(o_hdr_d), 66'(x[65:64]));
                end
            end
            if (valid_c && o_ready_c) begin
                model_beat(1, {32'h0, data_c}, 32, e);
                exp_c.push_back({hdr_c, 32'h0, e[31:0]});
                src_d.push_back({hdr_c, 32'h0, data_c});
            end
        end
    end

    task automatic send_a(input logic [63:0] d, input logic [1:0] h, input logic byp,
                          input logic sl, input logic [57:0] sd);
        int waited = 0;
        data_a = d; hdr_a = h; bypass_a = byp; seed_load_a = sl; seed_a = sd; valid_a = 1'b1;
        @(negedge clk);
        while (!o_ready_a && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready_a) check_eq("a_accept_timeout", 66'(o_ready_a), 66'd1);
        @(posedge clk); #1;
        valid_a = 1'b0; bypass_a = 1'b0; seed_load_a = 1'b0;
    endtask

    task automatic send_c(input logic [31:0] d, input logic [1:0] h);
        int waited = 0;
        data_c = d; hdr_c = h; valid_c = 1'b1;
        @(negedge clk);
        while (!o_ready_c && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready_c) check_eq("c_accept_timeout", 66'(o_ready_c), 66'd1);
        @(posedge clk); #1;
        valid_c = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : p_main
        logic [63:0] d;
        // Reset state
        idle(3);
        rst_a = 1'b0; rst_c = 1'b0;
        check_eq("rst_o_valid", 66'(o_valid_a), 66'd0);
        check_eq("rst_o_data", 66'(o_data_a), 66'd0);
        check_eq("rst_o_hdr", 66'(o_hdr_a), 66'd0);
        check_eq("rst_o_ready", 66'(o_ready_a), 66'd1);

        // Known vector: all-ones seed, zero payload
        send_a(64'h0, 2'b01, 1'b0, 1'b0, 58'h0);
        check_eq("vec_valid", 66'(o_valid_a), 66'd1);
        check_eq("vec_data", 66'(o_data_a), 66'h03FF_FF80_0000_0000);
        check_eq("vec_hdr", 66'(o_hdr_a), 66'd1);

        // Loopback with random downstream backpressure
        bp_rand = 1'b1;
        for (int k = 0; k < 1000; k++)
            send_a({$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 58'h0);
        bp_rand = 1'b0;
        idle(6);
        check_eq("loop_drain_a", 66'(exp_a.size()), 66'd0);
        check_eq("loop_drain_b", 66'(src_b.size()), 66'd0);

        // Sustained backpressure: fill both stages, then hold
        ready_force = 1'b0;
        send_a({$urandom, $urandom}, 2'b10, 1'b0, 1'b0, 58'h0);
        send_a({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 58'h0);
        fork
            send_a({$urandom, $urandom}, 2'b10, 1'b0, 1'b0, 58'h0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_ready", 66'(o_ready_a), 66'd0);
                    check_eq("bp_valid", 66'(o_valid_a), 66'd1);
                    check_eq("bp_hold", 66'(o_data_a), 66'(exp_a[0][63:0]));
                end
                @(posedge clk); #1;
                ready_force = 1'b1;
            end
        join
        idle(6);
        check_eq("bp_drain_a", 66'(exp_a.size()), 66'd0);
        check_eq("bp_drain_b", 66'(src_b.size()), 66'd0);

        // Bypass in the middle of a scrambled run
        chk_b = 1'b0;
        send_a({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 58'h0);
        d = {$urandom, $urandom};
        send_a(d, 2'b10, 1'b1, 1'b0, 58'h0);
        check_eq("byp_data", 66'(o_data_a), 66'(d));
        send_a({$urandom, $urandom}, 2'b01, 1'b0, 1'b0, 58'h0);
        idle(3);

        // Seed load without an accept, then with one
        seed_a = {$urandom, $urandom} & c_SEED_ONES;
        seed_load_a = 1'b1;
        idle(1);
        seed_load_a = 1'b0;
        send_a({$urandom, $urandom}, 2'b10, 1'b0, 1'b0, 58'h0);
        send_a(64'h0, 2'b01, 1'b0, 1'b1, 58'h0);
        check_eq("seed0_data", 66'(o_data_a), 66'd0);
        for (int k = 0; k < 3; k++) begin
            send_a(64'h0, 2'b01, 1'b0, 1'b0, 58'h0);
            check_eq("seed0_zero_run", 66'(o_data_a), 66'd0);
        end
        idle(3);
        check_eq("seed_drain_a", 66'(exp_a.size()), 66'd0);

        // 32-bit chain with a reset pulse mid-stream
        bp_rand = 1'b1;
        for (int k = 0; k < 100; k++) send_c($urandom, 2'($urandom_range(0, 3)));
        rst_c = 1'b1;
        idle(1);
        rst_c = 1'b0;
        check_eq("rst_mid_c_valid", 66'(o_valid_c), 66'd0);
        check_eq("rst_mid_d_valid", 66'(o_valid_d), 66'd0);
        check_eq("rst_mid_c_ready", 66'(o_ready_c), 66'd1);
        for (int k = 0; k < 100; k++) send_c($urandom, 2'($urandom_range(0, 3)));
        bp_rand = 1'b0;
        idle(6);
        check_eq("w32_drain_c", 66'(exp_c.size()), 66'd0);
        check_eq("w32_drain_d", 66'(src_d.size()), 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
